// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared pipeline encodings, payload layouts and defaults
package cpu_pipe_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int STALL_W_DEF = 6;

    localparam logic IN_DELAY_SLOT     = 1'b1;
    localparam logic NOT_IN_DELAY_SLOT = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [4:0]  wd;
        logic        wreg;
        logic [14:0] rsvd;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [31:0] mem_addr;
        logic [31:0] reg2;
        logic [7:0]  aluop;
        logic [4:0]  wd;
        logic        wreg;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        wreg;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    localparam logic [ID_EX_W-1:0] NOP_PAYLOAD = '0;

    // One action per edge, listed in decreasing priority.
    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_ADVANCE = 2'd2,
        ACT_HOLD    = 2'd3
    } stage_act_e;

    function automatic stage_act_e decode_act(input logic flush, input logic up, input logic dn);
        if (flush)
            return ACT_FLUSH;
        else if (up == STOP && dn == NO_STOP)
            return ACT_BUBBLE;
        else if (up == NO_STOP)
            return ACT_ADVANCE;
        else
            return ACT_HOLD;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating event counter, cleared only by reset
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline boundary register with flush, bubble, hold and perf counters
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int               DATA_W    = ID_EX_W,
    parameter int               STALL_W   = STALL_W_DEF,
    parameter int               STAGE     = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_dslot,
    input  logic               next_dslot_i,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_dslot,
    output logic               dslot_o,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);

    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
            $fatal(1, "pipe_stage_reg: STAGE out of range for STALL_W");
        end
        if (DATA_W < 1) begin : g_bad_width
            $fatal(1, "pipe_stage_reg: DATA_W must be at least 1");
        end
    endgenerate

    logic       up;
    logic       dn;
    stage_act_e act;
    logic       do_bubble;
    logic       do_hold;

    assign up = stall[STAGE];
    assign dn = stall[STAGE+1];

    // Only two bits of the controller vector matter at this boundary.
    logic unused_stall;
    assign unused_stall = ^stall;

    always_comb begin
        act       = decode_act(flush, up, dn);
        do_bubble = 1'b0;
        do_hold   = 1'b0;
        case (act)
            ACT_BUBBLE: do_bubble = 1'b1;
            ACT_HOLD:   do_hold   = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= NOP_VALUE;
            out_dslot <= NOT_IN_DELAY_SLOT;
            dslot_o   <= NOT_IN_DELAY_SLOT;
        end else begin
            case (act)
                ACT_FLUSH: begin
                    out_valid <= 1'b0;
                    out_data  <= NOP_VALUE;
                    out_dslot <= NOT_IN_DELAY_SLOT;
                    dslot_o   <= NOT_IN_DELAY_SLOT;
                end
                ACT_BUBBLE: begin
                    // dslot_o is kept so the delay-slot marking survives the NOP.
                    out_valid <= 1'b0;
                    out_data  <= NOP_VALUE;
                    out_dslot <= NOT_IN_DELAY_SLOT;
                end
                ACT_ADVANCE: begin
                    out_valid <= in_valid;
                    out_data  <= in_data;
                    out_dslot <= in_dslot;
                    dslot_o   <= next_dslot_i;
                end
                default: ;
            endcase
        end
    end

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_bubble),
        .count (bubble_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_hold),
        .count (hold_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int SW = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_dslot;
    logic          next_dslot_i;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_dslot;
    logic          dslot_o;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] hold_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          ds;
        logic          dso;
        logic [CW-1:0] b;
        logic [CW-1:0] h;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W    (DW),
        .STALL_W   (SW),
        .STAGE     (2),
        .NOP_VALUE (16'h0000),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_dslot     (in_dslot),
        .next_dslot_i (next_dslot_i),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_dslot    (out_dslot),
        .dslot_o      (dslot_o),
        .bubble_cnt   (bubble_cnt),
        .hold_cnt     (hold_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [DW-1:0] d, input logic ds,
                                input logic dso, input int b, input int h);
        exp_t e;
        e.v   = v;
        e.d   = d;
        e.ds  = ds;
        e.dso = dso;
        e.b   = CW'(b);
        e.h   = CW'(h);
        return e;
    endfunction

    task automatic step(input logic [SW-1:0] s, input logic f, input logic iv,
                        input logic [DW-1:0] id, input logic ids, input logic nds, input exp_t e);
        @(negedge clk);
        stall        = s;
        flush        = f;
        in_valid     = iv;
        in_data      = id;
        in_dslot     = ids;
        next_dslot_i = nds;
        exp_q.push_back(e);
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".out_valid"},  32'(out_valid),  32'(e.v));
        chk({tag, ".out_data"},   32'(out_data),   32'(e.d));
        chk({tag, ".out_dslot"},  32'(out_dslot),  32'(e.ds));
        chk({tag, ".dslot_o"},    32'(dslot_o),    32'(e.dso));
        chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(e.b));
        chk({tag, ".hold_cnt"},   32'(hold_cnt),   32'(e.h));
    endtask

    // Monitor: one registered response per edge that had stimulus queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all("edge", e);
            end
        end
    end

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_dslot = 1'b0; next_dslot_i = 1'b0;
        #1;
        chk_all("reset0", mk(0, 16'h0000, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        // Load a valid entry, then reset mid-cycle with no clock edge.
        step(6'b000000, 0, 1, 16'hDEAD, 1, 1, mk(1, 16'hDEAD, 1, 1, 0, 0));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_rst", mk(0, 16'h0000, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        step(6'b000000, 0, 1, 16'h1234, 1, 1, mk(1, 16'h1234, 1, 1, 0, 0));
        for (int i = 1; i <= 3; i++)
            step(6'b000111, 0, 1, 16'h5555, 1, 0, mk(0, 16'h0000, 0, 1, i, 0));
        step(6'b000000, 0, 1, 16'hABCD, 0, 1, mk(1, 16'hABCD, 0, 1, 3, 0));
        for (int i = 1; i <= 5; i++)
            step(6'b001111, 0, 0, 16'h7777, 1, 0, mk(1, 16'hABCD, 0, 1, 3, i));
        step(6'b001111, 1, 1, 16'h8888, 1, 1, mk(0, 16'h0000, 0, 0, 3, 5));
        step(6'b001111, 0, 1, 16'h9191, 1, 1, mk(0, 16'h0000, 0, 0, 3, 6));
        step(6'b000000, 0, 0, 16'h4242, 1, 0, mk(0, 16'h4242, 1, 0, 3, 6));
        step(6'b001000, 0, 1, 16'h9999, 0, 1, mk(1, 16'h9999, 0, 1, 3, 6));
        for (int i = 1; i <= 20; i++)
            step(6'b000111, 0, 1, 16'h5A5A, 1, 0,
                 mk(0, 16'h0000, 0, 1, (3 + i > 15) ? 15 : 3 + i, 6));

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        #3;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
